// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched on accept; the result is committed when the busy counter expires.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic [31:0]        hi_q, lo_q;
  logic               busy_q;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg, is_div;
  logic [31:0] a_mag, b_mag, uq, ur, sq, sr;
  logic [31:0] hi_d, lo_d;
  logic        wr_d;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  always_comb begin
    is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    if (op_q == OP_MULT) begin
      a_ext = {{32{a_q[31]}}, a_q};
      b_ext = {{32{b_q[31]}}, b_q};
    end else begin
      a_ext = {32'd0, a_q};
      b_ext = {32'd0, b_q};
    end
    prod  = a_ext * b_ext;

    a_neg = (op_q == OP_DIV) && a_q[31];
    b_neg = (op_q == OP_DIV) && b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    uq    = 32'd0;
    ur    = 32'd0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    sq = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    sr = a_neg ? (~ur + 32'd1) : ur;

    if (is_div) begin
      hi_d = sr;
      lo_d = sq;
    end else begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end
    wr_d = !(is_div && (b_q == 32'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Req) begin
            case (MDUOp)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                a_q     <= MDU_A;
                b_q     <= MDU_B;
                op_q    <= MDUOp;
                cnt_q   <= ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU)) ?
                           CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
              OP_MTHI: hi_q <= MDU_A;
              OP_MTLO: lo_q <= MDU_A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
